// File: rtl/pa_riscv.sv
// ---------------------------------------------------------------------------
// pa_riscv -- shared definitions for the ALU arbiter slice.
//   XLEN            : datapath width of the shared ALU.
//   OP_*            : 4-bit ALU op encodings ({funct7[5], funct3} style).
//   arb_state_e     : arbiter FSM states (IDLE, EXEC, RESP).
//   op_is_legal()   : true for the five supported ops only.
// ---------------------------------------------------------------------------
package pa_riscv;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h8;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_AND = 4'h7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_OR)  || (op == OP_AND);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu -- purely combinational ALU shared by both requesters.
//   i_a, i_b  : operands (XLEN bits)
//   i_op      : op code (pa_riscv OP_*)
//   o_result  : result; forced to zero for an unsupported op
//   o_illegal : high when i_op is not one of the supported ops
// Add and subtract wrap modulo 2^XLEN.
// ---------------------------------------------------------------------------
module alu
    import pa_riscv::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [3:0]      i_op,
    output logic [XLEN-1:0] o_result,
    output logic            o_illegal
);

    always_comb begin
        o_result  = '0;
        o_illegal = !op_is_legal(i_op);
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_AND:  o_result = i_a & i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter -- two requesters share one ALU through a 3-state FSM.
//   FAIR          : 1 = round-robin on contention, 0 = requester 0 always wins
//   i_clk         : clock (rising edge)
//   i_arst_n      : asynchronous active-low reset
//   i_reqValid    : per-requester request valid
//   o_reqReady    : per-requester accept strobe (combinational, IDLE only)
//   i_reqA/B/Op   : per-requester operands and op
//   o_rspValid    : per-requester response valid (one-hot or zero)
//   i_rspReady    : per-requester response accept (only the granted bit counts)
//   o_rspResult   : registered result
//   o_rspZero     : registered zero flag of the result
//   o_rspIllegal  : registered unsupported-op flag
//   o_busy        : high whenever the FSM is not IDLE
// A grant in cycle T yields a response in cycle T+2; the earliest next grant
// is the cycle after the response handshake, so grants are >= 3 cycles apart.
// ---------------------------------------------------------------------------
module alu_arbiter
    import pa_riscv::*;
#(
    parameter int FAIR = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic [1:0]            i_reqValid,
    output logic [1:0]            o_reqReady,
    input  logic [1:0][XLEN-1:0]  i_reqA,
    input  logic [1:0][XLEN-1:0]  i_reqB,
    input  logic [1:0][3:0]       i_reqOp,
    output logic [1:0]            o_rspValid,
    input  logic [1:0]            i_rspReady,
    output logic [XLEN-1:0]       o_rspResult,
    output logic                  o_rspZero,
    output logic                  o_rspIllegal,
    output logic                  o_busy
);

    arb_state_e      state_q,   state_d;
    logic            ptr_q,     ptr_d;
    logic            gnt_q,     gnt_d;
    logic [XLEN-1:0] a_q,       a_d;
    logic [XLEN-1:0] b_q,       b_d;
    logic [3:0]      op_q,      op_d;
    logic [XLEN-1:0] result_q,  result_d;
    logic            zero_q,    zero_d;
    logic            illegal_q, illegal_d;

    logic            req_any;
    logic            req_pick;
    logic [XLEN-1:0] alu_result;
    logic            alu_illegal;

    alu u_alu (
        .i_a      (a_q),
        .i_b      (b_q),
        .i_op     (op_q),
        .o_result (alu_result),
        .o_illegal(alu_illegal)
    );

    // Winner selection; a lone requester always wins, the pointer only
    // matters under contention.
    always_comb begin
        req_any = |i_reqValid;
        if (i_reqValid == 2'b11) begin
            req_pick = (FAIR != 0) ? ptr_q : 1'b0;
        end else begin
            req_pick = i_reqValid[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        zero_d     = zero_q;
        illegal_d  = illegal_q;
        o_reqReady = '0;
        o_rspValid = '0;

        case (state_q)
            ST_IDLE: begin
                // The reset term keeps the accept strobe low while reset is
                // asserted even though the state already reads IDLE.
                if (req_any && i_arst_n) begin
                    o_reqReady[req_pick] = 1'b1;
                    gnt_d   = req_pick;
                    ptr_d   = ~req_pick;
                    a_d     = i_reqA[req_pick];
                    b_d     = i_reqB[req_pick];
                    op_d    = i_reqOp[req_pick];
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d  = alu_result;
                zero_d    = !alu_illegal && (alu_result == '0);
                illegal_d = alu_illegal;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                o_rspValid[gnt_q] = 1'b1;
                if (i_rspReady[gnt_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Captured operands are always written before they are consumed, so
    // they carry no reset.
    always_ff @(posedge i_clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

    assign o_rspResult  = result_q;
    assign o_rspZero    = zero_q;
    assign o_rspIllegal = illegal_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import pa_riscv::*;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [1:0]        reqValid = 2'b00;
    logic [1:0]        reqReady;
    logic [1:0][31:0]  reqA = '0;
    logic [1:0][31:0]  reqB = '0;
    logic [1:0][3:0]   reqOp = '0;
    logic [1:0]        rspValid;
    logic [1:0]        rspReady = 2'b00;
    logic [31:0]       rspResult;
    logic              rspZero;
    logic              rspIllegal;
    logic              busy;

    logic [1:0]        fp_reqValid = 2'b00;
    logic [1:0]        fp_reqReady;
    logic [1:0]        fp_rspValid;
    logic [1:0]        fp_rspReady = 2'b11;
    logic [31:0]       fp_rspResult;
    logic              fp_rspZero;
    logic              fp_rspIllegal;
    logic              fp_busy;

    int n_pass = 0;
    int n_tot  = 0;
    int m_ptr  = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1)) dut (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_reqValid(reqValid), .o_reqReady(reqReady),
        .i_reqA(reqA), .i_reqB(reqB), .i_reqOp(reqOp),
        .o_rspValid(rspValid), .i_rspReady(rspReady),
        .o_rspResult(rspResult), .o_rspZero(rspZero),
        .o_rspIllegal(rspIllegal), .o_busy(busy)
    );

    alu_arbiter #(.FAIR(0)) dut_fp (
        .i_clk(clk), .i_arst_n(arst_n),
        .i_reqValid(fp_reqValid), .o_reqReady(fp_reqReady),
        .i_reqA(reqA), .i_reqB(reqB), .i_reqOp(reqOp),
        .o_rspValid(fp_rspValid), .i_rspReady(fp_rspReady),
        .o_rspResult(fp_rspResult), .o_rspZero(fp_rspZero),
        .o_rspIllegal(fp_rspIllegal), .o_busy(fp_busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference ALU: {illegal, zero, result}
    function automatic logic [33:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        logic [31:0] r;
        logic        ill;
        r   = 32'h0;
        ill = 1'b0;
        if      (op == OP_ADD) r = a + b;
        else if (op == OP_SUB) r = a - b;
        else if (op == OP_AND) r = a & b;
        else if (op == OP_OR)  r = a | b;
        else if (op == OP_XOR) r = a ^ b;
        else                   ill = 1'b1;
        return {ill, (!ill && r == 32'h0), r};
    endfunction

    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return m_ptr;
    endfunction

    task automatic chk_rsp(input string tag, input int g, input logic [31:0] er,
                           input logic ez, input logic ei);
        chk({tag, ".rspValid"}, rspValid, 2'b01 << g);
        chk({tag, ".result"}, rspResult, er);
        chk({tag, ".zero"}, rspZero, ez);
        chk({tag, ".illegal"}, rspIllegal, ei);
        chk({tag, ".reqReady_resp"}, reqReady, 2'b00);
        chk({tag, ".busy_resp"}, busy, 1'b1);
    endtask

    // Entered just after a falling edge; leaves just after the falling edge
    // of the first IDLE cycle following the response handshake.
    task automatic txn(input logic [1:0] vld, input int hold, input int g,
                       input logic [31:0] er, input logic ez, input logic ei,
                       input string tag);
        reqValid = vld;
        rspReady = 2'b00;
        #1;
        chk({tag, ".grant"}, reqReady, 2'b01 << g);
        chk({tag, ".busy_idle"}, busy, 1'b0);
        chk({tag, ".rspValid_idle"}, rspValid, 2'b00);
        @(negedge clk); #1;
        chk({tag, ".reqReady_exec"}, reqReady, 2'b00);
        chk({tag, ".busy_exec"}, busy, 1'b1);
        chk({tag, ".rspValid_exec"}, rspValid, 2'b00);
        @(negedge clk);
        rspReady = (hold == 0) ? 2'b11 : (2'b01 << (1 - g));
        #1;
        chk_rsp(tag, g, er, ez, ei);
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (k == hold) rspReady = 2'b11;
            #1;
            chk_rsp({tag, ".hold"}, g, er, ez, ei);
        end
        @(negedge clk);
        rspReady = 2'b00;
        m_ptr = 1 - g;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            reqValid = 2'b00;
            #1;
            chk("idle.reqReady", reqReady, 2'b00);
            chk("idle.busy", busy, 1'b0);
            chk("idle.rspValid", rspValid, 2'b00);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] e;
        logic [1:0]  v;
        int          g;
        int          ng;
        logic [3:0]  ops[6];

        tbl[0] = '{32'd5,        32'd7,        OP_ADD, 32'd12,       1'b0, 1'b0};
        tbl[1] = '{32'd3,        32'd3,        OP_SUB, 32'd0,        1'b1, 1'b0};
        tbl[2] = '{32'h0000_00F0, 32'h0000_000F, OP_XOR, 32'h0000_00FF, 1'b0, 1'b0};
        tbl[3] = '{32'hFFFF_FFFF, 32'h1,        OP_ADD, 32'h0,        1'b1, 1'b0};
        tbl[4] = '{32'h0,        32'h1,        OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[5] = '{32'hF0F0_1234, 32'h0FF0_FFFF, OP_AND, 32'h00F0_1234, 1'b0, 1'b0};
        tbl[6] = '{32'h0000_00F0, 32'h0F00_0000, OP_OR,  32'h0F00_00F0, 1'b0, 1'b0};
        tbl[7] = '{32'd5,        32'd7,        4'hF,   32'h0,        1'b0, 1'b1};
        tbl[8] = '{32'd9,        32'd9,        4'h1,   32'h0,        1'b0, 1'b1};
        tbl[9] = '{32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0,        1'b1, 1'b0};
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, 4'hF};

        // Reset state, with both requesters already asserting valid
        reqValid = 2'b11;
        @(negedge clk); @(negedge clk); #1;
        chk("rst.reqReady", reqReady, 2'b00);
        chk("rst.rspValid", rspValid, 2'b00);
        chk("rst.result", rspResult, 32'h0);
        chk("rst.zero", rspZero, 1'b0);
        chk("rst.illegal", rspIllegal, 1'b0);
        chk("rst.busy", busy, 1'b0);
        @(negedge clk);
        reqValid = 2'b00;
        arst_n = 1'b1;
        m_ptr = 0;

        // Table of single-requester operations
        for (int i = 0; i < 10; i++) begin
            reqA[0]  = tbl[i].a;
            reqB[0]  = tbl[i].b;
            reqOp[0] = tbl[i].op;
            txn(2'b01, i % 3, 0, tbl[i].res, tbl[i].zero, tbl[i].ill, $sformatf("tbl%0d", i));
        end
        idle(2);

        // Fresh reset, then simultaneous requests
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        m_ptr = 0;
        reqA[0] = 32'd3;     reqB[0] = 32'd3;     reqOp[0] = OP_SUB;
        reqA[1] = 32'h00F0;  reqB[1] = 32'h000F;  reqOp[1] = OP_XOR;
        txn(2'b11, 0, 0, 32'h0, 1'b1, 1'b0, "both.r0");
        txn(2'b11, 0, 1, 32'hFF, 1'b0, 1'b0, "both.r1");

        // Back-to-back contention alternates under round robin
        for (int i = 0; i < 4; i++) begin
            reqA[0] = $urandom; reqB[0] = $urandom; reqOp[0] = OP_ADD;
            reqA[1] = $urandom; reqB[1] = $urandom; reqOp[1] = OP_OR;
            g = exp_grant(2'b11);
            e = ref_alu(reqA[g], reqB[g], reqOp[g]);
            txn(2'b11, 0, g, e[31:0], e[32], e[33], $sformatf("rr%0d", i));
        end
        idle(1);

        // Long response stall on requester 1, requester 0 valid and ready
        reqA[0] = 32'd1; reqB[0] = 32'd2; reqOp[0] = OP_ADD;
        txn(2'b01, 0, 0, 32'd3, 1'b0, 1'b0, "stall.pre");
        reqA[1] = 32'h1234_5678; reqB[1] = 32'h0000_0078; reqOp[1] = OP_SUB;
        txn(2'b11, 5, 1, 32'h1234_5600, 1'b0, 1'b0, "stall");
        idle(1);

        // Fixed-priority instance under constant contention
        ng = 0;
        fp_reqValid = 2'b11;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (fp_reqReady != 2'b00) begin
                ng++;
                chk("fp.grant", fp_reqReady, 2'b01);
            end
            @(negedge clk);
        end
        fp_reqValid = 2'b00;
        chk("fp.count", ng, 10);
        idle(1);

        // Reset while in EXEC discards the operation and the pointer
        reqA[1] = 32'd1; reqB[1] = 32'd1; reqOp[1] = OP_ADD;
        txn(2'b10, 0, 1, 32'd2, 1'b0, 1'b0, "prerst");
        reqA[0] = 32'd4; reqB[0] = 32'd4; reqOp[0] = OP_ADD;
        reqValid = 2'b11;
        #1;
        chk("exrst.grant", reqReady, 2'b01);
        @(negedge clk); #1;
        chk("exrst.busy", busy, 1'b1);
        chk("exrst.prev_result", rspResult, 32'd2);
        #2;
        arst_n = 1'b0;
        #1;
        chk("exrst.reqReady", reqReady, 2'b00);
        chk("exrst.busy0", busy, 1'b0);
        chk("exrst.rspValid", rspValid, 2'b00);
        chk("exrst.result", rspResult, 32'h0);
        chk("exrst.zero", rspZero, 1'b0);
        chk("exrst.illegal", rspIllegal, 1'b0);
        @(negedge clk); @(negedge clk);
        arst_n = 1'b1;
        m_ptr = 0;
        txn(2'b11, 0, 0, 32'd8, 1'b0, 1'b0, "postrst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                reqA[r]  = $urandom;
                reqB[r]  = ($urandom_range(0, 3) == 0) ? reqA[r] : $urandom;
                reqOp[r] = ($urandom_range(0, 7) == 0) ? 4'($urandom)
                                                        : ops[$urandom_range(0, 5)];
            end
            g = exp_grant(v);
            e = ref_alu(reqA[g], reqB[g], reqOp[g]);
            txn(v, $urandom_range(0, 3), g, e[31:0], e[32], e[33], $sformatf("rnd%0d", i));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FAIR, default 1, SHALL select round-robin grant when 1 and fixed priority (requester 0 wins) when 0.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_arst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_reqValid  input  2  SHALL be the per-requester request valid (bit n = requester n).
REQ-005 o_reqReady  output  2  SHALL be the per-requester request accept strobe.
REQ-006 i_reqA  input  2x32  SHALL be the per-requester operand A.
REQ-007 i_reqB  input  2x32  SHALL be the per-requester operand B.
REQ-008 i_reqOp  input  2x4  SHALL be the per-requester ALU operation, encoded per pa_riscv.
REQ-009 o_rspValid  output  2  SHALL be the per-requester response valid, at most one bit set.
REQ-010 i_rspReady  input  2  SHALL be the per-requester response accept.
REQ-011 o_rspResult  output  32  SHALL be the shared registered result bus.
REQ-012 o_rspZero  output  1  SHALL be the registered zero flag for o_rspResult.
REQ-013 o_rspIllegal  output  1  SHALL flag an op outside {ADD, SUB, AND, OR, XOR}.
REQ-014 o_busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 FSM SHALL have states IDLE, EXEC and RESP.
REQ-016 IDLE, any i_reqValid high: SHALL grant one requester and assert its o_reqReady combinationally for that cycle only.
REQ-017 The grant cycle SHALL capture operands and op into internal registers and move to EXEC.
REQ-018 o_reqReady SHALL be 0 in EXEC and RESP.
REQ-019 Only one requester valid: it SHALL be granted.
REQ-020 Both valid, FAIR=1: the requester named by the priority pointer SHALL be granted.
REQ-021 After each grant to n, the priority pointer SHALL become 1-n.
REQ-022 EXEC: the captured operands SHALL drive the shared ALU, whose result and zero flag are registered.
REQ-023 EXEC SHALL always last exactly one cycle and then move to RESP.
REQ-024 Latency: handshake in cycle T SHALL give o_rspValid[grant]=1 in cycle T+2.
REQ-025 Illegal op: o_rspResult SHALL be 32'h0, o_rspZero 0 and o_rspIllegal 1; otherwise o_rspIllegal SHALL be 0.
REQ-026 RESP: o_rspValid[grant], o_rspResult, o_rspZero and o_rspIllegal SHALL hold stable until i_rspReady[grant] is high.
REQ-027 i_rspReady of the non-granted requester SHALL be ignored.
REQ-028 Response handshake: the FSM SHALL move to IDLE and o_rspValid SHALL clear on the next cycle.
REQ-029 No new grant SHALL occur in the handshake cycle; minimum spacing between grants is 3 cycles.
REQ-030 Width rule: SUB SHALL be two's-complement modulo 2^32; ADD overflow SHALL wrap silently.

Reset
REQ-031 Asserting i_arst_n low SHALL, with no clock required, force: state IDLE, priority pointer 0, o_rspValid 0, o_reqReady 0, o_rspResult 0, o_rspZero 0, o_rspIllegal 0, o_busy 0.
REQ-032 Reset in EXEC or RESP SHALL discard the in-flight operation; the requester SHALL reissue it.
REQ-033 After deassertion, the first grant SHALL be on the first rising edge with the state in IDLE.

Structure
REQ-034 The state enum (IDLE, EXEC, RESP) SHALL be defined in pa_riscv next to the ALU op encodings.
REQ-035 The op-legality check SHALL use only the pa_riscv op constants; there SHALL be no literal op values in alu_arbiter.
REQ-036 alu_arbiter SHALL instantiate exactly one alu sub-module; arbitration, FSM and response registers SHALL stay in alu_arbiter.

Verification
REQ-037 After reset: req0 ADD A=5, B=7 -> o_reqReady[0] pulses 1 cycle; two cycles later o_rspValid=2'b01, result 12, zero 0.
REQ-038 After reset: req0 SUB 3-3 and req1 XOR 0xF0^0x0F issued together -> req0 first (result 0, zero 1), then req1 (result 0xFF).
REQ-039 Both requesters valid every cycle, rspReady held high, FAIR=1 -> grants alternate 0,1,0,1 with 3-cycle spacing.
REQ-040 Both requesters valid every cycle, FAIR=0 -> every grant goes to requester 0.
REQ-041 i_rspReady[1] held low for 5 cycles during RESP -> outputs stable, o_reqReady stays 0, i_rspReady[0]=1 ignored.
REQ-042 Two cases: op 4'hF -> result 0, o_rspIllegal 1. Reset in EXEC -> all outputs 0 asynchronously and the next grant goes to requester 0.
